// File: rtl/matrix_coproc_pkg.sv
// matrix_coproc_pkg -- shared encodings and helpers for matrix_coproc_seq.
//   Opcodes (cmd_op), matrix selects (cmd_sel), FSM state encodings,
//   ALU lane operation codes, and reduce_w(), the full-width to W-bit rule.
//   Optional feature macro: MATRIX_COPROC_SATURATE_EN
//     defined   -> out-of-range results clamp to the W-bit signed limits
//     undefined -> out-of-range results wrap (low W bits kept)
package matrix_coproc_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_MULE  = 3'b101;
  localparam logic [2:0] OP_MULM  = 3'b110;
  localparam logic [2:0] OP_CLR   = 3'b111;

  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_C   = 2'd2;
  localparam logic [1:0] SEL_ERR = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic [1:0] LANE_ADD = 2'd0;
  localparam logic [1:0] LANE_SUB = 2'd1;
  localparam logic [1:0] LANE_MUL = 2'd2;
  localparam logic [1:0] LANE_MAC = 2'd3;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MULE) || (op == OP_MULM);
  endfunction

  // Reduce a sign-extended full-width value to a width-bit signed result.
  // The caller truncates the returned value to width bits.
  function automatic logic signed [63:0] reduce_w(input logic signed [63:0] value,
                                                  input int width);
`ifdef MATRIX_COPROC_SATURATE_EN
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
`else
    logic signed [63:0] shl;
    shl = value <<< (64 - width);
    return shl >>> (64 - width);
`endif
  endfunction

endpackage

// File: rtl/matrix_coproc_seq_alu_lane.sv
// coproc_alu_lane -- combinational single-element arithmetic lane.
//   op   : LANE_ADD (a+b), LANE_SUB (a-b), LANE_MUL (a*b), LANE_MAC (acc+a*b)
//   a, b : W-bit signed operands
//   acc  : FW-bit signed accumulator input (MAC only)
//   full : FW-bit signed exact result (FW = 2W+AW, wide enough for N products)
//   ovf  : full lies outside the W-bit signed range
module coproc_alu_lane
  import matrix_coproc_pkg::*;
#(
  parameter int W  = 8,
  parameter int AW = 3,
  localparam int FW = 2 * W + AW
) (
  input  logic [1:0]           op,
  input  logic signed [W-1:0]  a,
  input  logic signed [W-1:0]  b,
  input  logic signed [FW-1:0] acc,
  output logic signed [FW-1:0] full,
  output logic                 ovf
);

  localparam logic signed [FW-1:0] MAX_V = {{(FW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [FW-1:0] MIN_V = {{(FW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [FW-1:0] a_x;
  logic signed [FW-1:0] b_x;
  logic signed [FW-1:0] prod;

  assign a_x  = {{(FW-W){a[W-1]}}, a};
  assign b_x  = {{(FW-W){b[W-1]}}, b};
  assign prod = a_x * b_x;

  always_comb begin
    full = a_x + b_x;
    case (op)
      LANE_SUB: full = a_x - b_x;
      LANE_MUL: full = prod;
      LANE_MAC: full = acc + prod;
      default:  full = a_x + b_x;
    endcase
  end

  assign ovf = (full > MAX_V) || (full < MIN_V);

endmodule

// File: rtl/matrix_coproc_seq.sv
// matrix_coproc_seq -- sequential N x N signed matrix coprocessor.
//   Holds matrices A, B and C; runs one command at a time, one element
//   (or one multiply-accumulate) per EXEC cycle.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     cmd_valid / cmd_ready    command handshake (ready only in IDLE)
//     cmd_op, cmd_sel          opcode, matrix select for LOAD/STORE
//     cmd_row, cmd_col         element index
//     cmd_data                 STORE value / MULE scalar
//     rsp_data                 LOAD result, held until the next LOAD
//     done                     one-cycle completion pulse
//     busy                     high in EXEC and DONE
//     overflow                 sticky overflow of the last arithmetic command
//     addr_err                 address error of the last LOAD/STORE
//   Optional feature macro: MATRIX_COPROC_SATURATE_EN (saturate vs wrap).
module matrix_coproc_seq
  import matrix_coproc_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 8,
  localparam int AW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [1:0]          cmd_sel,
  input  logic [AW-1:0]       cmd_row,
  input  logic [AW-1:0]       cmd_col,
  input  logic signed [W-1:0] cmd_data,
  output logic signed [W-1:0] rsp_data,
  output logic                done,
  output logic                busy,
  output logic                overflow,
  output logic                addr_err
);

  localparam int FW = 2 * W + AW;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t               state;
  logic [2:0]           op_q;
  logic [1:0]           sel_q;
  logic [AW-1:0]        row_q, col_q;
  logic signed [W-1:0]  data_q;
  logic [AW-1:0]        cnt_i, cnt_j, cnt_k;
  logic signed [FW-1:0] acc_q;

  logic signed [W-1:0]  mat_a [N][N];
  logic signed [W-1:0]  mat_b [N][N];
  logic signed [W-1:0]  mat_c [N][N];

  logic [1:0]           lane_op;
  logic signed [W-1:0]  lane_a, lane_b;
  logic signed [FW-1:0] lane_acc, lane_full;
  logic                 lane_ovf;
  logic signed [W-1:0]  red_w;
  logic                 last_step;
  logic                 addr_ok;
  logic signed [W-1:0]  rd_val;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  // Operand routing: MULM walks A[i][k] x B[k][j]; the accumulator restarts at k=0.
  always_comb begin
    lane_op  = LANE_ADD;
    lane_a   = mat_a[cnt_i][cnt_j];
    lane_b   = mat_b[cnt_i][cnt_j];
    lane_acc = '0;
    case (op_q)
      OP_SUB:  lane_op = LANE_SUB;
      OP_MULE: begin
        lane_op = LANE_MUL;
        lane_b  = data_q;
      end
      OP_MULM: begin
        lane_op  = LANE_MAC;
        lane_a   = mat_a[cnt_i][cnt_k];
        lane_b   = mat_b[cnt_k][cnt_j];
        lane_acc = (cnt_k == '0) ? '0 : acc_q;
      end
      default: ;
    endcase
  end

  coproc_alu_lane #(.W(W), .AW(AW)) u_lane (
    .op   (lane_op),
    .a    (lane_a),
    .b    (lane_b),
    .acc  (lane_acc),
    .full (lane_full),
    .ovf  (lane_ovf)
  );

  assign red_w = W'(reduce_w({{(64-FW){lane_full[FW-1]}}, lane_full}, W));

  always_comb begin
    case (op_q)
      OP_ADD, OP_SUB, OP_MULE: last_step = (cnt_i == LAST) && (cnt_j == LAST);
      OP_MULM: last_step = (cnt_i == LAST) && (cnt_j == LAST) && (cnt_k == LAST);
      default: last_step = 1'b1;
    endcase
  end

  assign addr_ok = (sel_q != SEL_ERR) && (row_q <= LAST) && (col_q <= LAST);

  always_comb begin
    rd_val = '0;
    if (addr_ok) begin
      case (sel_q)
        SEL_A:   rd_val = mat_a[row_q][col_q];
        SEL_B:   rd_val = mat_b[row_q][col_q];
        SEL_C:   rd_val = mat_c[row_q][col_q];
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= OP_NOP;
      sel_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      data_q   <= '0;
      cnt_i    <= '0;
      cnt_j    <= '0;
      cnt_k    <= '0;
      rsp_data <= '0;
      overflow <= 1'b0;
      addr_err <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mat_a[r][c] <= '0;
          mat_b[r][c] <= '0;
          mat_c[r][c] <= '0;
        end
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            sel_q  <= cmd_sel;
            row_q  <= cmd_row;
            col_q  <= cmd_col;
            data_q <= cmd_data;
            cnt_i  <= '0;
            cnt_j  <= '0;
            cnt_k  <= '0;
            state  <= ST_EXEC;
            if (is_arith(cmd_op)) overflow <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (last_step) state <= ST_DONE;
          case (op_q)
            OP_LOAD: begin
              addr_err <= !addr_ok;
              rsp_data <= rd_val;
            end
            OP_STORE: begin
              addr_err <= !addr_ok;
              if (addr_ok) begin
                case (sel_q)
                  SEL_A:   mat_a[row_q][col_q] <= data_q;
                  SEL_B:   mat_b[row_q][col_q] <= data_q;
                  default: mat_c[row_q][col_q] <= data_q;
                endcase
              end
            end
            OP_ADD, OP_SUB, OP_MULE, OP_MULM: begin
              // Elementwise ops retire an element every cycle; MULM only on its last k.
              if (op_q != OP_MULM || cnt_k == LAST) begin
                mat_c[cnt_i][cnt_j] <= red_w;
                overflow            <= overflow | lane_ovf;
                cnt_k               <= '0;
                if (cnt_j == LAST) begin
                  cnt_j <= '0;
                  cnt_i <= (cnt_i == LAST) ? '0 : cnt_i + 1'b1;
                end else begin
                  cnt_j <= cnt_j + 1'b1;
                end
              end else begin
                cnt_k <= cnt_k + 1'b1;
              end
            end
            OP_CLR: begin
              overflow <= 1'b0;
              addr_err <= 1'b0;
              for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                  mat_a[r][c] <= '0;
                  mat_b[r][c] <= '0;
                  mat_c[r][c] <= '0;
                end
              end
            end
            default: ;
          endcase
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // MULM running sum; fully rebuilt from k=0, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == ST_EXEC && op_q == OP_MULM) acc_q <= lane_full;
  end

endmodule

// File: tb/tb_matrix_coproc_seq.sv
module tb_matrix_coproc_seq;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int AW = 3;

  localparam int T_NOP = 0, T_LOAD = 1, T_STORE = 2, T_ADD = 3;
  localparam int T_SUB = 4, T_MULE = 5, T_MULM = 6, T_CLR = 7;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          cmd_op;
  logic [1:0]          cmd_sel;
  logic [AW-1:0]       cmd_row, cmd_col;
  logic signed [W-1:0] cmd_data;
  logic signed [W-1:0] rsp_data;
  logic                done, busy, overflow, addr_err;

  int n_cmp = 0;
  int n_err = 0;
  int last_lat;

  // Reference state
  int ma [N][N];
  int mb [N][N];
  int mc [N][N];
  int m_rsp;
  bit m_ovf, m_aerr;

  always #5 clk = ~clk;

  matrix_coproc_seq #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_data(cmd_data), .rsp_data(rsp_data), .done(done), .busy(busy),
    .overflow(overflow), .addr_err(addr_err)
  );

  function automatic int m_red(int v);
`ifdef MATRIX_COPROC_SATURATE_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
`else
    int r;
    r = v & 255;
    if (r > 127) r = r - 256;
    return r;
`endif
  endfunction

  function automatic bit m_isovf(int v);
    return (v > 127) || (v < -128);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 0; mb[i][j] = 0; mc[i][j] = 0;
      end
    m_rsp = 0; m_ovf = 0; m_aerr = 0;
  endfunction

  function automatic void apply_model(int op, int sel, int row, int col, int data);
    bit ok;
    int s, v;
    ok = (sel != 3) && (row < N) && (col < N);
    case (op)
      T_LOAD: begin
        m_aerr = !ok;
        m_rsp = 0;
        if (ok) m_rsp = (sel == 0) ? ma[row][col] : (sel == 1) ? mb[row][col] : mc[row][col];
      end
      T_STORE: begin
        m_aerr = !ok;
        if (ok) begin
          if (sel == 0) ma[row][col] = data;
          else if (sel == 1) mb[row][col] = data;
          else mc[row][col] = data;
        end
      end
      T_ADD, T_SUB, T_MULE, T_MULM: begin
        m_ovf = 0;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            if (op == T_ADD) v = ma[i][j] + mb[i][j];
            else if (op == T_SUB) v = ma[i][j] - mb[i][j];
            else if (op == T_MULE) v = ma[i][j] * data;
            else begin
              s = 0;
              for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
              v = s;
            end
            mc[i][j] = m_red(v);
            if (m_isovf(v)) m_ovf = 1;
          end
      end
      T_CLR: begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            ma[i][j] = 0; mb[i][j] = 0; mc[i][j] = 0;
          end
        m_ovf = 0; m_aerr = 0;
      end
      default: ;
    endcase
  endfunction

  // Issue one command, update the model at the accept edge, wait for done.
  task automatic do_cmd(input int op, input int sel, input int row, input int col, input int data);
    int g;
    g = 0;
    @(negedge clk);
    while (!cmd_ready && g < 300) begin @(negedge clk); g++; end
    cmd_op = op[2:0]; cmd_sel = sel[1:0]; cmd_row = row[2:0]; cmd_col = col[2:0];
    cmd_data = data[7:0];
    cmd_valid = 1'b1;
    @(posedge clk);
    apply_model(op, sel, row, col, data);
    @(negedge clk);
    cmd_valid = 1'b0;
    last_lat = 1;
    while (!done && last_lat < 2000) begin @(negedge clk); last_lat++; end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL done_timeout op=%0d: no done after %0d cycles, required a done pulse", op, last_lat);
    end
  endtask

  task automatic test_reset();
    logic [7:0] e8;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", cmd_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done); end
    n_cmp++; if (rsp_data !== 8'sd0) begin n_err++; $display("FAIL rst_rsp got %0d want 0", rsp_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", overflow); end
    n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL rst_aerr got %b want 0", addr_err); end
    @(negedge clk); rst = 1'b0;
    model_reset();
    do_cmd(T_LOAD, 2, 4, 4, 0);
    e8 = 8'd0;
    n_cmp++; if (rsp_data !== e8) begin n_err++; $display("FAIL rst_loadC got %0d want 0", rsp_data); end
    n_cmp++; if (last_lat != 2) begin n_err++; $display("FAIL load_latency got %0d want 2", last_lat); end
  endtask

  task automatic test_mulm();
    int cv [4];
    int e;
    cv = '{19, 22, 43, 50};
    do_cmd(T_CLR, 0, 0, 0, 0);
    n_cmp++; if (last_lat != 2) begin n_err++; $display("FAIL clr_latency got %0d want 2", last_lat); end
    do_cmd(T_STORE, 0, 0, 0, 1); do_cmd(T_STORE, 0, 0, 1, 2);
    do_cmd(T_STORE, 0, 1, 0, 3); do_cmd(T_STORE, 0, 1, 1, 4);
    n_cmp++; if (last_lat != 2) begin n_err++; $display("FAIL store_latency got %0d want 2", last_lat); end
    do_cmd(T_STORE, 1, 0, 0, 5); do_cmd(T_STORE, 1, 0, 1, 6);
    do_cmd(T_STORE, 1, 1, 0, 7); do_cmd(T_STORE, 1, 1, 1, 8);
    do_cmd(T_MULM, 0, 0, 0, 0);
    n_cmp++; if (last_lat != 1 + N*N*N) begin n_err++; $display("FAIL mulm_latency got %0d want %0d", last_lat, 1 + N*N*N); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mulm_ovf got %b want 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      do_cmd(T_LOAD, 2, i / 2, i % 2, 0);
      e = cv[i];
      n_cmp++; if (rsp_data !== e[7:0]) begin n_err++; $display("FAIL mulm_c%0d got %0d want %0d", i, rsp_data, e); end
    end
  endtask

  task automatic test_add_ovf();
    int e;
    do_cmd(T_STORE, 0, 0, 0, 100);
    do_cmd(T_STORE, 1, 0, 0, 100);
    do_cmd(T_ADD, 0, 0, 0, 0);
    n_cmp++; if (last_lat != 1 + N*N) begin n_err++; $display("FAIL add_latency got %0d want %0d", last_lat, 1 + N*N); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL add_ovf got %b want 1", overflow); end
    do_cmd(T_LOAD, 2, 0, 0, 0);
`ifdef MATRIX_COPROC_SATURATE_EN
    e = 127;
`else
    e = -56;
`endif
    n_cmp++; if (rsp_data !== e[7:0]) begin n_err++; $display("FAIL add_c00 got %0d want %0d", rsp_data, e); end
    do_cmd(T_NOP, 0, 0, 0, 0);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL nop_keeps_ovf got %b want 1", overflow); end
    do_cmd(T_SUB, 0, 0, 0, 0);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL sub_clears_ovf got %b want 0", overflow); end
    do_cmd(T_LOAD, 2, 1, 1, 0);
    n_cmp++; if (rsp_data !== 8'hFC) begin n_err++; $display("FAIL sub_c11 got %0d want -4", rsp_data); end
  endtask

  task automatic test_mule_clr();
    int e;
    do_cmd(T_LOAD, 3, 0, 0, 0);
    do_cmd(T_CLR, 0, 0, 0, 0);
    n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL clr_aerr got %b want 0", addr_err); end
    do_cmd(T_STORE, 0, 1, 1, -64);
    do_cmd(T_MULE, 0, 0, 0, 2);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mule2_ovf got %b want 0", overflow); end
    do_cmd(T_LOAD, 2, 1, 1, 0);
    n_cmp++; if (rsp_data !== 8'h80) begin n_err++; $display("FAIL mule2_c11 got %0d want -128", rsp_data); end
    do_cmd(T_MULE, 0, 0, 0, 3);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL mule3_ovf got %b want 1", overflow); end
    do_cmd(T_LOAD, 2, 1, 1, 0);
`ifdef MATRIX_COPROC_SATURATE_EN
    e = -128;
`else
    e = 64;
`endif
    n_cmp++; if (rsp_data !== e[7:0]) begin n_err++; $display("FAIL mule3_c11 got %0d want %0d", rsp_data, e); end
  endtask

  task automatic test_addr_err();
    do_cmd(T_STORE, 0, 5, 0, 55);
    n_cmp++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL store_row5_aerr got %b want 1", addr_err); end
    for (int r = 0; r < N; r++) begin
      do_cmd(T_LOAD, 0, r, 0, 0);
      n_cmp++; if (rsp_data !== 8'd0) begin n_err++; $display("FAIL a_unchanged r%0d got %0d want 0", r, rsp_data); end
    end
    do_cmd(T_LOAD, 0, 1, 1, 0);
    n_cmp++; if (rsp_data !== 8'hC0 || addr_err !== 1'b0) begin n_err++; $display("FAIL load_a11 got %0d/%b want -64/0", rsp_data, addr_err); end
    do_cmd(T_LOAD, 3, 1, 1, 0);
    n_cmp++; if (rsp_data !== 8'd0 || addr_err !== 1'b1) begin n_err++; $display("FAIL load_sel3 got %0d/%b want 0/1", rsp_data, addr_err); end
    do_cmd(T_STORE, 1, 0, 7, 9);
    n_cmp++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL store_col7_aerr got %b want 1", addr_err); end
    do_cmd(T_STORE, 2, 4, 4, 9);
    n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL store_c_ok got %b want 0", addr_err); end
    do_cmd(T_LOAD, 2, 4, 4, 0);
    n_cmp++; if (rsp_data !== 8'd9) begin n_err++; $display("FAIL store_c_readback got %0d want 9", rsp_data); end
  endtask

  task automatic test_random();
    int ops [4];
    int op, el, sel, row, col, dat;
    ops = '{T_ADD, T_SUB, T_MULE, T_MULM};
    for (int rnd = 0; rnd < 4; rnd++) begin
      for (int s = 0; s < 8; s++) begin
        sel = ($urandom_range(0, 7) == 0) ? 2 : int'($urandom_range(0, 1));
        row = $urandom_range(0, 5);
        col = $urandom_range(0, 4);
        dat = int'($urandom_range(0, 255)) - 128;
        do_cmd(T_STORE, sel, row, col, dat);
        n_cmp++; if (addr_err !== m_aerr) begin n_err++; $display("FAIL rnd_store_aerr got %b want %b", addr_err, m_aerr); end
      end
      op = ops[rnd];
      dat = int'($urandom_range(0, 255)) - 128;
      do_cmd(op, 0, 0, 0, dat);
      n_cmp++; if (last_lat != ((op == T_MULM) ? 1 + N*N*N : 1 + N*N)) begin n_err++; $display("FAIL rnd_latency op=%0d got %0d", op, last_lat); end
      n_cmp++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf op=%0d got %b want %b", op, overflow, m_ovf); end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          do_cmd(T_LOAD, 2, i, j, 0);
          el = m_rsp;
          n_cmp++; if (rsp_data !== el[7:0]) begin n_err++; $display("FAIL rnd_c op=%0d (%0d,%0d) got %0d want %0d", op, i, j, rsp_data, el); end
        end
    end
  endtask

  task automatic test_reset_mid();
    int g;
    do_cmd(T_STORE, 0, 0, 0, 5);
    do_cmd(T_STORE, 1, 0, 0, 7);
    do_cmd(T_STORE, 2, 2, 2, 9);
    @(negedge clk);
    g = 0;
    while (!cmd_ready && g < 300) begin @(negedge clk); g++; end
    cmd_op = 3'd6; cmd_sel = 2'd0; cmd_row = '0; cmd_col = '0; cmd_data = '0;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_ready got %b/%b want 1/0", cmd_ready, busy); end
    model_reset();
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done got %b want 0", done); end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_no_done got %b want 0", done); end
    end
    do_cmd(T_LOAD, 0, 0, 0, 0);
    n_cmp++; if (rsp_data !== 8'd0) begin n_err++; $display("FAIL midrst_a00 got %0d want 0", rsp_data); end
    do_cmd(T_LOAD, 1, 0, 0, 0);
    n_cmp++; if (rsp_data !== 8'd0) begin n_err++; $display("FAIL midrst_b00 got %0d want 0", rsp_data); end
    do_cmd(T_LOAD, 2, 2, 2, 0);
    n_cmp++; if (rsp_data !== 8'd0) begin n_err++; $display("FAIL midrst_c22 got %0d want 0", rsp_data); end
  endtask

  task automatic test_back_to_back();
    int r, c, v, op_cur, last_op, last_acc, n_acc, g;
    logic [7:0] e8;
    r = $urandom_range(0, 4); c = $urandom_range(0, 4); v = int'($urandom_range(0, 255)) - 128;
    @(negedge clk);
    g = 0;
    while (!cmd_ready && g < 300) begin @(negedge clk); g++; end
    op_cur = T_STORE;
    cmd_op = op_cur[2:0]; cmd_sel = 2'd1; cmd_row = r[2:0]; cmd_col = c[2:0]; cmd_data = v[7:0];
    cmd_valid = 1'b1;
    last_op = -1; last_acc = -1; n_acc = 0;
    for (int cyc = 0; cyc < 36; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (done && last_op == T_LOAD) begin
        e8 = m_rsp[7:0];
        n_cmp++; if (rsp_data !== e8) begin n_err++; $display("FAIL b2b_load got %0d want %0d", rsp_data, m_rsp); end
      end
      if (busy) begin
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_busy got %b want 0", cmd_ready); end
      end
      if (cmd_ready) begin
        apply_model(op_cur, 1, r, c, v);
        if (last_acc >= 0) begin
          n_cmp++; if (cyc - last_acc != 3) begin n_err++; $display("FAIL b2b_gap got %0d want 3", cyc - last_acc); end
        end
        last_acc = cyc; last_op = op_cur; n_acc++;
        @(posedge clk); #1;
        if (op_cur == T_STORE) op_cur = T_LOAD;
        else begin
          op_cur = T_STORE;
          r = $urandom_range(0, 4); c = $urandom_range(0, 4); v = int'($urandom_range(0, 255)) - 128;
        end
        cmd_op = op_cur[2:0]; cmd_row = r[2:0]; cmd_col = c[2:0]; cmd_data = v[7:0];
      end
    end
    cmd_valid = 1'b0;
    n_cmp++; if (n_acc != 12) begin n_err++; $display("FAIL b2b_accepts got %0d want 12", n_acc); end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_sel = '0; cmd_row = '0; cmd_col = '0; cmd_data = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_mulm();
    test_add_ovf();
    test_mule_clr();
    test_addr_err();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_coproc_seq.md
# matrix_coproc_seq

Parametrised, sequential matrix coprocessor: the successor of the fixed 5×5, 8-bit coprocessor. It holds three N×N signed matrices (A, B, result C) and executes one command at a time over a valid/ready command port. Arithmetic runs one element, or one multiply-accumulate, per cycle. It sits between the host command bus and the result readback path.

## Interface
- N, 5, matrix dimension (2..8)
- W, 8, element width, signed two's complement
- AW, $clog2(N), row/column index width (derived, not overridable)
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  3  NOP=000, LOAD=001, STORE=010, ADD=011, SUB=100, MULE=101, MULM=110, CLR=111
- cmd_sel  in  2  matrix select for STORE/LOAD: 0=A, 1=B, 2=C; 3 is an address error
- cmd_row, cmd_col  in  AW each  element index
- cmd_data  in  W  STORE value; scalar for MULE
- rsp_data  out  W  LOAD result, held until the next LOAD
- done  out  1  one-cycle pulse at command completion
- busy  out  1  high in EXEC and DONE
- overflow  out  1  sticky per arithmetic command
- addr_err  out  1  result of the last STORE/LOAD

## Operation
- States: IDLE, EXEC, DONE.
  - IDLE→EXEC on cmd_valid && cmd_ready. The command and its operands are latched at that edge.
  - EXEC→DONE when the element counter reaches its last step.
  - DONE→IDLE unconditionally.
- STORE: write cmd_data to the selected element in EXEC (1 cycle).
  - If row≥N, col≥N, or sel=3: addr_err=1 and nothing is written.
  - Otherwise addr_err=0.
  - STORE to C is legal.
- LOAD: rsp_data ← selected element in EXEC (1 cycle).
  - Address check is the same as STORE.
  - On an error, rsp_data=0.
- ADD/SUB/MULE: elementwise A±B or A×scalar into C, row-major, N² EXEC cycles.
  - The intermediate is W+1 bits for ADD/SUB and 2W bits for MULE, then reduced to W.
- MULM: C=A×B, N³ EXEC cycles, innermost loop over k.
  - Accumulator width is 2W+AW.
  - The accumulator is cleared at k=0 and written to C at k=N−1.
- Reduction to W: overflow is set if the full-width value lies outside [−2^(W−1), 2^(W−1)−1]. The stored value depends on the macro (see Configuration).
- overflow: cleared when an arithmetic command is accepted; OR-accumulates during that command; holds until the next arithmetic command, CLR, or reset.
- CLR: zero A, B and C, and clear overflow and addr_err (1 EXEC cycle).
- NOP: 1 EXEC cycle, no state change.
- Flags not named in a command's description are left unchanged by that command.
- C reads during EXEC return the pre-command contents, except for elements already written by the running command.

## Timing
- Reset values (asserted asynchronously): state=IDLE, cmd_ready=1, busy=0, done=0, rsp_data=0, overflow=0, addr_err=0, counters=0, all matrices zero.
- Command latency from the accept edge to the done pulse: 1+L cycles.
  - L=1 for NOP/LOAD/STORE/CLR.
  - L=N² for ADD/SUB/MULE.
  - L=N³ for MULM.
- The next command can be accepted in the cycle after done, so the throughput gap is L+2 cycles per command.
- cmd_ready is combinational from state. cmd_valid held during EXEC/DONE is ignored and not queued.
- rsp_data and addr_err are valid in the same cycle as done.
- Reset mid-command: the command is aborted, no done pulse, matrices are zeroed.
- Counter wrap: the column counter wraps at N−1 into a row increment; the last step is the (N−1,N−1[,N−1]) tuple. Indices ≥N are never generated.

## Configuration
- MATRIX_COPROC_SATURATE_EN
  - Defined: overflowing results clamp to 2^(W−1)−1 or −2^(W−1).
  - Undefined: results wrap, keeping the low W bits.
  - overflow is flagged identically in both builds.

## Structure
- Package matrix_coproc_pkg:
  - opcode localparams
  - state enum
  - sel encodings
  - function reduce_w(value, width) implementing the saturate/wrap rule under the macro
- Sub-module coproc_alu_lane: combinational single-element ADD/SUB/MUL/MAC with full-width output and overflow detect. It is instantiated once; the FSM, counters and matrix storage stay in the top module.

## Test plan
- N=2, W=8: STORE A=[[1,2],[3,4]], B=[[5,6],[7,8]]; MULM → done 9 cycles after accept; LOAD C gives 19, 22, 43, 50; overflow=0.
- STORE A(0,0)=100, B(0,0)=100; ADD → LOAD C(0,0): 127 with SATURATE_EN, −56 without; overflow=1 in both builds. A following NOP keeps overflow=1; a following SUB with no overflow clears it.
- MULE with A(1,1)=−64 and scalar 2 → C(1,1)=−128, overflow=0. Scalar 3 → overflow=1.
- N=2: STORE with row=2 → addr_err=1 and A unchanged on readback. LOAD with sel=3 → rsp_data=0, addr_err=1.
- Assert rst 3 cycles into MULM → no done pulse, cmd_ready=1 immediately, all LOADs return 0.
- Hold cmd_valid continuously with alternating STORE/LOAD commands → exactly one accept per 3 cycles; cmd_ready=0 while busy.
